// File: rtl/xor_stream_decrypt.sv
// rtl/xor_stream_decrypt.sv - serial XOR-key stream decryptor with byte packer and 2-deep output FIFO
// Optional per-frame plaintext checksum is built when XOR_DEC_CHECKSUM_EN is defined.
module xor_stream_decrypt #(
    parameter int KEY_SIZE = 32,
    parameter int MSG_SIZE = 512
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic [KEY_SIZE-1:0] iKey,
    input  logic                iKey_load,
    input  logic                iSerial_in,
    input  logic                iSerial_start,
    input  logic                iSerial_end,
    input  logic                iByte_ready,
    output logic [7:0]          oByte,
    output logic                oByte_valid,
    output logic                oFrame_done,
    output logic                oFrame_err,
    output logic                oOverrun,
    output logic [7:0]          oChecksum
);

    localparam int CW = $clog2(MSG_SIZE) + 1;
    localparam int KW = (KEY_SIZE > 1) ? $clog2(KEY_SIZE) : 1;

    typedef enum logic {IDLE, RECV} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [KW-1:0]       kidx_q, kidx_d;
    logic [KEY_SIZE-1:0] key_q, key_d;
    logic [KEY_SIZE-1:0] fkey_q, fkey_d;
    logic [6:0]          sr_q, sr_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [KW-1:0]       cur_kidx, kidx_nxt, key_sel;
    logic [KEY_SIZE-1:0] cur_key;
    logic                pbit, push, last;
    logic [7:0]          byte_w;

    logic [7:0]          mem_q [2];
    logic                rd_q, wr_q;
    logic [1:0]          fcnt_q, fcnt_d;
    logic                ovr_q;
    logic                pop, full, wr_en, drop;

    // A start pulse always begins a frame at key index 0 with the committed key; fkey_q
    // holds the key the running frame started with so a coincident load only affects the next frame.
    always_comb begin
        cur_kidx = iSerial_start ? '0 : kidx_q;
        cur_key  = iSerial_start ? key_q : fkey_q;
        key_sel  = KW'(KEY_SIZE - 1) - cur_kidx;
        pbit     = iSerial_in ^ cur_key[key_sel];
        byte_w   = {sr_q, pbit};
        kidx_nxt = (cur_kidx == KW'(KEY_SIZE - 1)) ? '0 : cur_kidx + 1'b1;
        last     = ((cnt_q + 1'b1) == CW'(MSG_SIZE));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kidx_d  = kidx_q;
        key_d   = key_q;
        fkey_d  = fkey_q;
        sr_d    = sr_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        push    = 1'b0;
        if (state_q == IDLE) begin
            if (iKey_load) key_d = iKey;
            if (iSerial_start) begin
                state_d = RECV;
                cnt_d   = CW'(1);
                kidx_d  = kidx_nxt;
                fkey_d  = key_q;
                sr_d    = {sr_q[5:0], pbit};
            end
        end else if (iSerial_start) begin
            err_d  = 1'b1;
            cnt_d  = CW'(1);
            kidx_d = kidx_nxt;
            fkey_d = key_q;
            sr_d   = {sr_q[5:0], pbit};
        end else begin
            cnt_d  = cnt_q + 1'b1;
            kidx_d = kidx_nxt;
            sr_d   = {sr_q[5:0], pbit};
            push   = (cnt_q[2:0] == 3'd7);
            if (iSerial_end || last) begin
                state_d = IDLE;
                cnt_d   = '0;
                kidx_d  = '0;
                done_d  = iSerial_end && last;
                err_d   = !(iSerial_end && last);
            end
        end
    end

    always_comb begin
        pop    = (fcnt_q != 2'd0) && iByte_ready;
        full   = (fcnt_q == 2'd2);
        wr_en  = push && (!full || pop);
        drop   = push && full && !pop;
        fcnt_d = fcnt_q + 2'(wr_en) - 2'(pop);
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            kidx_q  <= '0;
            key_q   <= '0;
            fkey_q  <= '0;
            sr_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            fcnt_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kidx_q  <= kidx_d;
            key_q   <= key_d;
            fkey_q  <= fkey_d;
            sr_q    <= sr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (wr_en) begin
                mem_q[wr_q] <= byte_w;
                wr_q        <= ~wr_q;
            end
            if (pop) rd_q <= ~rd_q;
            fcnt_q  <= fcnt_d;
            ovr_q   <= ovr_q | drop;
        end
    end

    assign oByte       = mem_q[rd_q];
    assign oByte_valid = (fcnt_q != 2'd0);
    assign oFrame_done = done_q;
    assign oFrame_err  = err_q;
    assign oOverrun    = ovr_q;

`ifdef XOR_DEC_CHECKSUM_EN
    logic [7:0] acc_q, acc_d, csum_q, csum_d;

    always_comb begin
        acc_d  = acc_q;
        csum_d = csum_q;
        if (iSerial_start) acc_d = '0;
        else if (push)     acc_d = acc_q ^ byte_w;
        if (done_d)        csum_d = acc_d;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            acc_q  <= '0;
            csum_q <= '0;
        end else begin
            acc_q  <= acc_d;
            csum_q <= csum_d;
        end
    end

    assign oChecksum = csum_q;
`else
    assign oChecksum = '0;
`endif

endmodule

// File: tb/tb_xor_stream_decrypt.sv
// tb/tb_xor_stream_decrypt.sv - directed self-checking bench for xor_stream_decrypt
module tb_xor_stream_decrypt;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] key;
    logic        key_load, serial, start, end_s, ready;
    logic [7:0]  byte_o, csum_o;
    logic        valid_o, done_o, err_o, ovr_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt, err_cnt;
    logic [7:0]  got[$];
    logic [7:0]  exp_q[$];

    xor_stream_decrypt #(.KEY_SIZE(32), .MSG_SIZE(512)) dut (
        .iClk(clk), .iRst(rst), .iKey(key), .iKey_load(key_load),
        .iSerial_in(serial), .iSerial_start(start), .iSerial_end(end_s),
        .iByte_ready(ready), .oByte(byte_o), .oByte_valid(valid_o),
        .oFrame_done(done_o), .oFrame_err(err_o), .oOverrun(ovr_o),
        .oChecksum(csum_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    // Plaintext stream is bytes 0,1,2,... sent MSB first, XORed with the repeating key.
    function automatic logic cbit(input logic [31:0] k, input int n);
        logic [7:0] b;
        b = 8'(n / 8);
        return b[7 - (n % 8)] ^ k[31 - (n % 32)];
    endfunction

    task automatic cyc(input logic s, input logic st, input logic en, input logic rdy, input logic ld);
        @(negedge clk);
        serial = s; start = st; end_s = en; ready = rdy; key_load = ld;
        if (valid_o && rdy) got.push_back(byte_o);
        if (done_o) done_cnt++;
        if (err_o) err_cnt++;
    endtask

    task automatic send(input logic [31:0] k, input int nbits, input int end_at, input int rdy_from, input logic ld0);
        for (int i = 0; i < nbits; i++)
            cyc(cbit(k, i), i == 0, i == end_at, i >= rdy_from, ld0 && (i == 0));
    endtask

    task automatic drain(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic clear_obs();
        got.delete();
        exp_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic expect_seq(input int first, input int last, input logic [31:0] kmask);
        for (int b = first; b <= last; b++)
            exp_q.push_back(8'(b) ^ kmask[31 - 8 * (b % 4) -: 8]);
    endtask

    task automatic check_bytes(input string tag);
        check_eq({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got.size()) check_eq($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
    endtask

    initial begin
        rst = 1'b1; key = '0; key_load = 1'b0; serial = 1'b0;
        start = 1'b0; end_s = 1'b0; ready = 1'b1;
        done_cnt = 0; err_cnt = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_byte", byte_o, 0);
        check_eq("rst_valid", valid_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_err", err_o, 0);
        check_eq("rst_ovr", ovr_o, 0);
        check_eq("rst_csum", csum_o, 0);
        rst = 1'b0;

        key = 32'hDEADBEEF;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        clear_obs();
        send(32'hDEADBEEF, 512, 511, 0, 1'b0);
        drain(12);
        expect_seq(0, 63, 32'h0);
        check_bytes("good");
        check_eq("good_done", done_cnt, 1);
        check_eq("good_err", err_cnt, 0);
        check_eq("good_ovr", ovr_o, 0);
        check_eq("good_csum", csum_o, 8'h00);

        clear_obs();
        send(32'hDEADBEEF, 512, 511, 40, 1'b0);
        drain(12);
        expect_seq(0, 1, 32'h0);
        expect_seq(5, 63, 32'h0);
        check_bytes("bp");
        check_eq("bp_ovr", ovr_o, 1);
        check_eq("bp_done", done_cnt, 1);

        clear_obs();
        send(32'hDEADBEEF, 101, 100, 0, 1'b0);
        repeat (16) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drain(12);
        expect_seq(0, 11, 32'h0);
        check_bytes("early");
        check_eq("early_err", err_cnt, 1);
        check_eq("early_done", done_cnt, 0);
        check_eq("early_idle_valid", valid_o, 0);

        clear_obs();
        send(32'hDEADBEEF, 37, -1, 0, 1'b0);
        send(32'hDEADBEEF, 512, 511, 0, 1'b0);
        drain(12);
        expect_seq(0, 3, 32'h0);
        expect_seq(0, 63, 32'h0);
        check_bytes("restart");
        check_eq("restart_err", err_cnt, 1);
        check_eq("restart_done", done_cnt, 1);

        clear_obs();
        key = 32'h12345678;
        send(32'hDEADBEEF, 512, 511, 0, 1'b1);
        drain(12);
        send(32'h12345678, 512, 511, 0, 1'b0);
        drain(12);
        expect_seq(0, 63, 32'h0);
        expect_seq(0, 63, 32'h0);
        check_bytes("race");
        check_eq("race_done", done_cnt, 2);
        check_eq("race_err", err_cnt, 0);

        clear_obs();
        send(32'h12345678, 200, -1, 0, 1'b0);
        check_eq("prerst_count", got.size(), 24);
        @(negedge clk);
        rst = 1'b1; start = 1'b0; serial = 1'b0; end_s = 1'b0;
        #1;
        check_eq("midrst_valid", valid_o, 0);
        check_eq("midrst_ovr", ovr_o, 0);
        check_eq("midrst_err", err_o, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_obs();
        send(32'hDEADBEEF, 512, 511, 0, 1'b0);
        drain(12);
        expect_seq(0, 63, 32'hDEADBEEF);
        check_bytes("key0");
        check_eq("key0_done", done_cnt, 1);
        check_eq("key0_err", err_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
